// File: rtl/core_nios_cpu_mult_unit.sv
// Pipelined integer multiplier for the Nios execute/memory path: four registered
// half-width partial products, reassembled into the low word or corrected high word.
module core_nios_cpu_mult_unit #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] E_src1,
   input  logic [DATA_W-1:0] E_src2,
   input  logic [1:0]        E_op,
   input  logic              E_valid,
   input  logic              M_en,
   input  logic              M_flush,
   output logic [DATA_W-1:0] M_mul_result,
   output logic              M_mul_valid,
   output logic              M_mul_busy
);

   localparam int unsigned HALF_W = DATA_W / 2;
   localparam int unsigned PROD_W = 2 * DATA_W;

   logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
   logic              a_signed, b_signed;
   logic [DATA_W-1:0] ll_d, lh_d, hl_d, hh_d, corr_d;

   assign a_lo = E_src1[HALF_W-1:0];
   assign a_hi = E_src1[DATA_W-1:HALF_W];
   assign b_lo = E_src2[HALF_W-1:0];
   assign b_hi = E_src2[DATA_W-1:HALF_W];

   always_comb begin
      a_signed = (E_op == 2'b01) || (E_op == 2'b10);
      b_signed = (E_op == 2'b01);
      ll_d     = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_lo};
      lh_d     = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_hi};
      hl_d     = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_lo};
      hh_d     = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_hi};
      // Signed high word = unsigned high word minus each negative operand's partner.
      corr_d   = '0;
      if (a_signed && E_src1[DATA_W-1])
         corr_d = E_src2;
      if (b_signed && E_src2[DATA_W-1])
         corr_d = corr_d + E_src1;
   end

   logic [DATA_W-1:0] s1_ll, s1_lh, s1_hl, s1_hh, s1_corr;
   logic [1:0]        s1_op;
   logic              s1_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_ll    <= '0;
         s1_lh    <= '0;
         s1_hl    <= '0;
         s1_hh    <= '0;
         s1_corr  <= '0;
         s1_op    <= '0;
         s1_valid <= 1'b0;
      end else begin
         if (M_flush)
            s1_valid <= 1'b0;
         else if (M_en)
            s1_valid <= E_valid;
         if (M_en) begin
            s1_ll   <= ll_d;
            s1_lh   <= lh_d;
            s1_hl   <= hl_d;
            s1_hh   <= hh_d;
            s1_corr <= corr_d;
            s1_op   <= E_op;
         end
      end
   end

   logic [PROD_W-1:0] prod;
   logic [DATA_W-1:0] res_d;

   always_comb begin
      prod  = PROD_W'(s1_ll)
            + ((PROD_W'(s1_lh) + PROD_W'(s1_hl)) << HALF_W)
            + (PROD_W'(s1_hh) << DATA_W);
      res_d = prod[DATA_W-1:0];
      if (s1_op != 2'b00)
         res_d = prod[PROD_W-1:DATA_W] - s1_corr;
   end

   logic [DATA_W-1:0] s2_result;
   logic              s2_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_result <= '0;
         s2_valid  <= 1'b0;
      end else begin
         if (M_flush)
            s2_valid <= 1'b0;
         else if (M_en)
            s2_valid <= s1_valid;
         if (M_en)
            s2_result <= res_d;
      end
   end

   generate
      if (PIPE_STAGES == 3) begin : g_out_reg
         logic [DATA_W-1:0] s3_result;
         logic              s3_valid;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s3_result <= '0;
               s3_valid  <= 1'b0;
            end else begin
               if (M_flush)
                  s3_valid <= 1'b0;
               else if (M_en)
                  s3_valid <= s2_valid;
               if (M_en)
                  s3_result <= s2_result;
            end
         end

         assign M_mul_result = s3_result;
         assign M_mul_valid  = s3_valid;
         assign M_mul_busy   = s1_valid | s2_valid | s3_valid;
      end else begin : g_no_out_reg
         assign M_mul_result = s2_result;
         assign M_mul_valid  = s2_valid;
         assign M_mul_busy   = s1_valid | s2_valid;
      end
   endgenerate

endmodule

// File: tb/tb_core_nios_cpu_mult_unit.sv
// Scoreboard bench: 2- and 3-stage instances share stimulus; a 64-bit arithmetic
// reference model predicts each result and the enabled-edge count it must appear at.
module tb_core_nios_cpu_mult_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] E_src1 = '0, E_src2 = '0;
   logic [1:0]  E_op = '0;
   logic        E_valid = 1'b0, M_en = 1'b0, M_flush = 1'b0;
   logic [31:0] r2, r3;
   logic        v2, v3, busy2, busy3;

   always #5 clk = ~clk;

   core_nios_cpu_mult_unit #(.DATA_W(32), .PIPE_STAGES(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .E_src1(E_src1), .E_src2(E_src2), .E_op(E_op),
      .E_valid(E_valid), .M_en(M_en), .M_flush(M_flush),
      .M_mul_result(r2), .M_mul_valid(v2), .M_mul_busy(busy2));

   core_nios_cpu_mult_unit #(.DATA_W(32), .PIPE_STAGES(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .E_src1(E_src1), .E_src2(E_src2), .E_op(E_op),
      .E_valid(E_valid), .M_en(M_en), .M_flush(M_flush),
      .M_mul_result(r3), .M_mul_valid(v3), .M_mul_busy(busy3));

   typedef struct {
      logic [31:0] val;
      int          due;
   } exp_t;

   exp_t        q2[$], q3[$];
   int          checks = 0, failures = 0;
   int          en_cnt = 0;
   logic        edge_live = 1'b0, edge_fl = 1'b0, edge_adv = 1'b0;
   logic [31:0] held[2];
   logic        prev_v[2];

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      logic [63:0] av, bv, p;
      av = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      bv = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = av * bv;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Issue tracker: records what each edge did to the pipeline.
   always @(posedge clk) begin : tracker
      exp_t e;
      edge_live = reset_n;
      edge_fl   = reset_n && M_flush;
      edge_adv  = reset_n && M_en && !M_flush;
      if (edge_fl) begin
         q2.delete();
         q3.delete();
      end else if (edge_adv) begin
         en_cnt++;
         if (E_valid) begin
            e.val = ref_mul(E_src1, E_src2, E_op);
            e.due = en_cnt + 1;
            q2.push_back(e);
            e.due = en_cnt + 2;
            q3.push_back(e);
         end
      end
   end

   task automatic mon(input int id, input logic v, input logic [31:0] r, input logic busy);
      exp_t e;
      int   n;
      if (!edge_live) begin
         prev_v[id] = 1'b0;
         return;
      end
      if (id == 0) n = q2.size(); else n = q3.size();
      if (n > 0) begin
         if (id == 0) e = q2[0]; else e = q3[0];
      end
      if (edge_fl) begin
         checks++;
         if (v !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear[P%0d] valid=%b busy=%b required 0/0", id + 2, v, busy);
         end
      end else if (edge_adv) begin
         if (v === 1'b1) begin
            checks++;
            if (n == 0) begin
               failures++;
               $display("FAIL unexpected_valid[P%0d] result=%h at edge %0d, nothing expected",
                        id + 2, r, en_cnt);
            end else begin
               if (id == 0) void'(q2.pop_front()); else void'(q3.pop_front());
               if (r !== e.val || en_cnt != e.due) begin
                  failures++;
                  $display("FAIL result[P%0d] got %h at edge %0d, required %h at edge %0d",
                           id + 2, r, en_cnt, e.val, e.due);
               end
            end
         end else if (n > 0 && e.due <= en_cnt) begin
            checks++;
            failures++;
            $display("FAIL missing_valid[P%0d] valid=%b at edge %0d, required %h at edge %0d",
                     id + 2, v, en_cnt, e.val, e.due);
            if (id == 0) void'(q2.pop_front()); else void'(q3.pop_front());
         end
      end else begin
         checks++;
         if (v !== prev_v[id] || (v === 1'b1 && r !== held[id])) begin
            failures++;
            $display("FAIL stall_hold[P%0d] got valid=%b result=%h, required valid=%b result=%h",
                     id + 2, v, r, prev_v[id], held[id]);
         end
      end
      prev_v[id] = v;
      held[id]   = r;
   endtask

   always @(posedge clk) begin : monitor
      #1;
      mon(0, v2, r2, busy2);
      mon(1, v3, r3, busy3);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("reset_result_p2", r2, 32'h0);
      chk("reset_valid_p2", {31'b0, v2}, 32'h0);
      chk("reset_busy_p2", {31'b0, busy2}, 32'h0);
      chk("reset_result_p3", r3, 32'h0);
      chk("reset_valid_p3", {31'b0, v3}, 32'h0);
      chk("reset_busy_p3", {31'b0, busy3}, 32'h0);
   endtask

   task automatic cyc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic v, input logic en, input logic fl);
      E_src1  = a;
      E_src2  = b;
      E_op    = op;
      E_valid = v;
      M_en    = en;
      M_flush = fl;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
   endtask

   function automatic logic [31:0] rnd_operand();
      logic [31:0] corner[5];
      corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++)
         cyc(rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
   endtask

   task automatic mulxss_vectors();
      cyc(32'h0000_0007, 32'h0000_0006, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b1, 1'b1, 1'b0);
      cyc(32'h8000_0000, 32'h8000_0000, 2'b01, 1'b1, 1'b1, 1'b0);
      cyc(32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 1'b1, 1'b1, 1'b0);
      cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b1, 1'b0);
      idle(4);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      prev_v = '{1'b0, 1'b0};
      held   = '{32'h0, 32'h0};
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs();
      reset_n = 1'b1;
      idle(2);

      // single pulse, then back-to-back wraparound low/high words
      cyc(32'd7, 32'd6, 2'b00, 1'b1, 1'b1, 1'b0);
      idle(4);
      cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b1, 1'b0);
      idle(4);
      mulxss_vectors();

      // stall: inputs during M_en=0 must be ignored
      cyc(32'd3, 32'd5, 2'b00, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc($urandom, $urandom, 2'b01, 1'b1, 1'b0, 1'b0);
      cyc('0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
      cyc('0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
      cyc('0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
      idle(4);

      // flush kills in-flight work and the op presented with it
      cyc(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 1'b1, 1'b1, 1'b0);
      cyc(32'h0000_0011, 32'h0000_0022, 2'b00, 1'b1, 1'b1, 1'b1);
      cyc(32'h0000_0009, 32'h0000_0009, 2'b00, 1'b1, 1'b1, 1'b0);
      idle(4);
      cyc(32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 1'b1, 1'b1, 1'b0);
      cyc(32'h1234_5678, 32'h9ABC_DEF0, 2'b10, 1'b1, 1'b0, 1'b1);
      idle(4);

      random_phase(400);

      // asynchronous reset between edges with work in flight
      cyc(32'hDEAD_BEEF, 32'h0000_0003, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(32'h8000_0001, 32'h8000_0001, 2'b01, 1'b1, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs();
      q2.delete();
      q3.delete();
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs();
      reset_n = 1'b1;
      idle(2);
      chk("post_reset_valid_p2", {31'b0, v2}, 32'h0);
      chk("post_reset_valid_p3", {31'b0, v3}, 32'h0);

      mulxss_vectors();
      random_phase(200);
      idle(6);
      chk("drain_pending_p2", q2.size(), 32'd0);
      chk("drain_pending_p3", q3.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_nios_cpu_mult_unit.md
Name: core_nios_cpu_mult_unit

Overview:
- Parametrised, pipelined integer multiplier for the Nios CPU execute/memory path.
- Successor to the fixed 3×16-bit partial-product cell.
- Splits each DATA_W operand into two halves and registers all four partial products.
- Reassembles the full 2·DATA_W product and returns either the low word or the signed/unsigned-corrected high word (mul, mulxss, mulxsu, mulxuu).
- Carries valid, stall and flush control alongside the data.

Parameters:
- DATA_W, 32, operand and result width; must be even and ≥8. HALF_W = DATA_W/2 is derived, not overridable.
- PIPE_STAGES, 2, latency in enabled cycles; legal values 2 or 3. 3 adds an output register.

Ports:
- clk  in  1  clock; all registers rise-edge.
- reset_n  in  1  asynchronous active-low reset.
- E_src1  in  DATA_W  operand A; rs1 semantics for signed ops.
- E_src2  in  DATA_W  operand B; rs2 semantics.
- E_op  in  2  00 mul (low word), 01 mulxss, 10 mulxsu (A signed, B unsigned), 11 mulxuu.
- E_valid  in  1  operands/op valid this cycle.
- M_en  in  1  pipeline advance. When 0, every stage register holds.
- M_flush  in  1  synchronous kill of all in-flight operations.
- M_mul_result  out  DATA_W  selected result word.
- M_mul_valid  out  1  M_mul_result holds a completed operation.
- M_mul_busy  out  1  OR of all internal valid bits, including the output stage.

Behaviour:
- Reset (reset_n=0, asynchronous): all data, op and valid registers clear to 0. M_mul_result=0, M_mul_valid=0, M_mul_busy=0. Reset mid-operation discards in-flight work; no residue after release.
- Stage 1 (captures on clk edge with M_en=1):
  - Registers four unsigned HALF_W×HALF_W products: ll=A[lo]*B[lo], lh=A[lo]*B[hi], hl=A[hi]*B[lo], hh=A[hi]*B[hi]; each is DATA_W bits.
  - Registers E_op and E_valid.
  - Registers correction term C = (A signed & A[MSB] ? B : 0) + (B signed & B[MSB] ? A : 0), mod 2^DATA_W.
  - Signedness: A is signed for ops 01 and 10; B is signed for op 01 only.
- Stage 2:
  - P = ll + ((lh+hl) << HALF_W) + (hh << DATA_W), computed at 2·DATA_W+1 bits internally, truncated to 2·DATA_W.
  - Result: op 00 → P[DATA_W-1:0]; other ops → (P[2DW-1:DW] − C) mod 2^DATA_W.
  - PIPE_STAGES=2: stage 2 drives M_mul_result/M_mul_valid through registers.
  - PIPE_STAGES=3: stage 2 result is registered once more before the outputs.
- Latency: an operation captured with E_valid=1 on enabled edge k appears with M_mul_valid=1 after enabled edge k+PIPE_STAGES−1. Disabled cycles do not count.
- Throughput: one operation per enabled cycle; fully pipelined, no internal back-pressure.
- Stall: with M_en=0, M_mul_result and M_mul_valid hold their values indefinitely. E_src*/E_op/E_valid are ignored.
- Flush: M_flush=1 at an edge clears all valid bits, including the output stage, regardless of M_en. Data registers may keep stale values.
  - M_flush together with E_valid: the new operation is also discarded.
  - Flush has priority over M_en.
- Bubbles: a stage with valid=0 still updates data when M_en=1. M_mul_result content is don't-care whenever M_mul_valid=0; the bench must not check it.
- Edge cases:
  - Overflow of the low word wraps silently.
  - Most-negative × most-negative in mulxss is exact; no saturation.
- No combinational path from any input to any output.

Test Plan:
- PIPE_STAGES=2, M_en=1: mul 7×6, E_valid pulse → M_mul_result=0x0000002A, M_mul_valid=1 exactly 2 edges later, 0 the next edge.
- Back-to-back ops: mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001, then mulxuu same operands → 0xFFFFFFFE on consecutive cycles, valid high 2 cycles.
- mulxss 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; mulxss 0x80000000×0x80000000 → 0x40000000; mulxsu 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Stall: issue mul 3×5, drop M_en for 3 cycles after edge 1 → no valid during stall; 0x0000000F valid after the 2nd enabled edge and held while M_en=0.
- Flush: two ops in flight, M_flush=1 for one edge → M_mul_valid and M_mul_busy stay 0. A fresh op issued next cycle completes normally.
- Reset mid-op, then PIPE_STAGES=3 regression of the mul/mulxss vectors:
  - Assert reset_n=0 asynchronously between edges → outputs 0 immediately.
  - Post-reset mulxss vectors match the expected results with 3-cycle latency.
